// File: rtl/sprite_motion_ctrl_if.sv
// Button inputs and position/status outputs of the sprite motion controller.
interface sprite_motion_ctrl_if #(
  parameter int COORD_W = 11
);
  logic               up;
  logic               down;
  logic               left;
  logic               right;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               moving;
  logic               fast;
  logic               tick;

  modport master (
    output up, down, left, right,
    input  x, y, moving, fast, tick
  );

  modport slave (
    input  up, down, left, right,
    output x, y, moving, fast, tick
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Tick-driven box position controller with diagonal moves and hold-to-accelerate.
// Define SPRITE_WRAP_EN to wrap at screen edges instead of clamping.
module sprite_motion_ctrl #(
  parameter int COORD_W     = 11,
  parameter int TICK_DIV    = 1666666,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BOX_W       = 32,
  parameter int BOX_H       = 32,
  parameter int STEP        = 2,
  parameter int ACCEL_TICKS = 30,
  parameter int X_INIT      = 200,
  parameter int Y_INIT      = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_motion_ctrl_if.slave  bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam int AW = COORD_W + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(ACCEL_TICKS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [AW-1:0] XMAX      = AW'(SCREEN_W - BOX_W);
  localparam logic [AW-1:0] YMAX      = AW'(SCREEN_H - BOX_H);
  localparam logic [AW-1:0] STEP_N    = AW'(STEP);
  localparam logic [AW-1:0] STEP_F    = AW'(2 * STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;

  logic [3:0]         sync1_q, sync2_q, prev_q, prev_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [HW-1:0]      hold_q, hold_d, hold_inc;
  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               moving_q, fast_q;
  logic               tick, xpos, xneg, ypos, yneg;
  logic               any_move, same, idle;
  logic [AW-1:0]      step, x_n, y_n;
  logic [3:0]         dir;

  assign dir    = sync2_q;
  assign tick   = (tcnt_q == TICK_LAST);
  assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

  assign xpos = dir[3] & ~dir[2];
  assign xneg = dir[2] & ~dir[3];
  assign ypos = dir[1] & ~dir[0];
  assign yneg = dir[0] & ~dir[1];

  assign any_move = xpos | xneg | ypos | yneg;
  assign same     = (dir == prev_q);
  assign idle     = (state_q == S_IDLE);
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    prev_d  = prev_q;
    unique case (1'b1)
      !tick: ;
      tick && !any_move: begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
      tick && any_move && (idle || !same): begin
        state_d = S_MOVE;
        hold_d  = HOLD_ONE;
        prev_d  = dir;
      end
      tick && any_move && !idle && same: begin
        if (state_q != S_FAST) begin
          hold_d  = hold_inc;
          state_d = (hold_inc == HOLD_MAX) ? S_FAST : S_MOVE;
        end
      end
    endcase
  end

  // A direction change drops back to normal speed on that same tick.
  assign step = (state_q == S_FAST && same) ? STEP_F : STEP_N;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p,
    input logic          pos,
    input logic          neg,
    input logic [AW-1:0] s,
    input logic [AW-1:0] mx
  );
    logic [AW-1:0] r;
    r = p;
    if (pos) begin
      r = p + s;
      if (r > mx) begin
`ifdef SPRITE_WRAP_EN
        r = r - (mx + AW'(1));
`else
        r = mx;
`endif
      end
    end else if (neg) begin
      if (p < s) begin
`ifdef SPRITE_WRAP_EN
        r = p + (mx + AW'(1)) - s;
`else
        r = '0;
`endif
      end else begin
        r = p - s;
      end
    end
    return r;
  endfunction

  assign x_n = nxt({1'b0, x_q}, xpos, xneg, step, XMAX);
  assign y_n = nxt({1'b0, y_q}, ypos, yneg, step, YMAX);
  assign x_d = tick ? x_n[COORD_W-1:0] : x_q;
  assign y_d = tick ? y_n[COORD_W-1:0] : y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      tcnt_q   <= '0;
      hold_q   <= '0;
      state_q  <= S_IDLE;
      x_q      <= COORD_W'(X_INIT);
      y_q      <= COORD_W'(Y_INIT);
      moving_q <= 1'b0;
      fast_q   <= 1'b0;
    end else begin
      sync1_q  <= {bus.right, bus.left, bus.down, bus.up};
      sync2_q  <= sync1_q;
      prev_q   <= prev_d;
      tcnt_q   <= tcnt_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      moving_q <= (state_d != S_IDLE);
      fast_q   <= (state_d == S_FAST);
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.moving = moving_q;
  assign bus.fast   = fast_q;
  assign bus.tick   = tick;
endmodule
